// File: rtl/decade_counter_if.sv
// Control/status bundle for one BCD decade counter digit.
// The master drives enable, direction and load; the slave (the counter)
// returns the registered count and the combinational terminal-count flag.
interface decade_counter_if;
    logic       counter_on;
    logic       count_up;
    logic       load;
    logic [3:0] data_in;
    logic [3:0] count;
    logic       TC;

    modport master (
        output counter_on,
        output count_up,
        output load,
        output data_in,
        input  count,
        input  TC
    );

    modport slave (
        input  counter_on,
        input  count_up,
        input  load,
        input  data_in,
        output count,
        output TC
    );
endinterface

// File: rtl/decade_counter.sv
// 4-bit BCD decade counter (modulus 10): up/down, enable, parallel load
// and a combinational terminal-count flag for cascading digits.
//
// Build option: DECADE_LOAD_CHECK_EN
//   defined   - loads of data_in > 9 are rejected; count holds.
//   undefined - data_in 10..15 loads as-is; the next count step pulls the
//               counter back into range (up -> 0, down -> 9).
module decade_counter (
    input  logic              clk,
    input  logic              reset,   // async, active low
    decade_counter_if.slave   bus
);
    localparam logic [3:0] MAX_DIGIT = 4'd9;

    logic [3:0] count_q;
    logic [3:0] count_nxt;
    logic       load_ok;
    logic       at_max;
    logic       at_min;

    // A load value is acceptable unless the range check is built in and it is not BCD.
    always_comb begin
        load_ok = 1'b1;
`ifdef DECADE_LOAD_CHECK_EN
        load_ok = (bus.data_in <= MAX_DIGIT);
`else
        load_ok = 1'b1;
`endif
    end

    // Next count: load beats counting, counting beats hold. Anything out of
    // range wraps like the terminal value so we recover within one step.
    always_comb begin
        count_nxt = count_q;
        if (bus.load) begin
            if (load_ok)
                count_nxt = bus.data_in;
        end else if (bus.counter_on) begin
            if (bus.count_up)
                count_nxt = (count_q >= MAX_DIGIT) ? 4'd0 : count_q + 4'd1;
            else
                count_nxt = (count_q == 4'd0 || count_q > MAX_DIGIT) ? MAX_DIGIT : count_q - 4'd1;
        end
    end

    // Count register; reset clears it immediately without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_q <= 4'd0;
        else
            count_q <= count_nxt;
    end

    // Terminal count flags that the next enabled edge wraps; it is never
    // set for an out-of-range count since neither compare can match.
    always_comb begin
        at_max = (count_q == MAX_DIGIT);
        at_min = (count_q == 4'd0);
    end

    assign bus.count = count_q;
    assign bus.TC    = bus.counter_on & ((bus.count_up & at_max) | (~bus.count_up & at_min));

endmodule

// File: tb/tb_decade_counter.sv
// Scoreboard bench for decade_counter: stimulus pushes hand-computed
// {count, TC} expectations; a monitor on the falling edge pops and compares.
module tb_decade_counter;
    logic clk;
    logic reset;

    decade_counter_if bus ();

    decade_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] c;
        logic       tc;
    } exp_t;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_push = 0;

    // Monitor: compare the DUT against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.count !== e.c || bus.TC !== e.tc) begin
                n_err++;
                $display("FAIL check#%0d count/TC: got count=%0d TC=%b, want count=%0d TC=%b",
                         n_cmp, bus.count, bus.TC, e.c, e.tc);
            end
        end
    end

    // Expect a value without a clock edge (used for async reset).
    task automatic chk_now(input logic [3:0] ec, input logic et);
        exp_q.push_back('{c: ec, tc: et});
        n_push++;
        @(negedge clk);
        #1;
    endtask

    // Apply inputs, take one rising edge, then expect the result.
    task automatic step(input logic on, input logic up, input logic ld,
                        input logic [3:0] din, input logic [3:0] ec, input logic et);
        bus.counter_on = on;
        bus.count_up   = up;
        bus.load       = ld;
        bus.data_in    = din;
        @(posedge clk);
        #1;
        exp_q.push_back('{c: ec, tc: et});
        n_push++;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int dn_seq [17];
        int up_seq [6];
        int ld_seq [3];
        dn_seq = '{9,8,7,6,5,4,3,2,1,0,9,8,7,6,5,4,3};
        up_seq = '{4,5,6,7,8,9};
        ld_seq = '{0,4,8};

        reset          = 1'b0;
        bus.counter_on = 1'b1;
        bus.count_up   = 1'b0;
        bus.load       = 1'b0;
        bus.data_in    = 4'd0;
        #2;

        // Reset held: count 0, down-enabled so TC=1.
        chk_now(4'd0, 1'b1);
        // Load during reset is ignored.
        step(1'b1, 1'b0, 1'b1, 4'd7, 4'd0, 1'b1);

        // Release; first edge counts down 0 -> 9, then down to 3.
        reset = 1'b1;
        for (int i = 0; i < 17; i++)
            step(1'b1, 1'b0, 1'b0, 4'd0, 4'(dn_seq[i]), dn_seq[i] == 0);

        // Switch to up at count 3: 4..9, then 0.
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 1'b0, 4'd0, 4'(up_seq[i]), up_seq[i] == 9);
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);

        // Back-to-back loads, latest data wins.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b1, 4'(ld_seq[i]), 4'(ld_seq[i]), 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd9, 1'b1);
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);

        // Disabled: hold at 0 for 5 edges, TC forced low (even with down selected).
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 1'b0);

        // Load beats count.
        step(1'b1, 1'b1, 1'b1, 4'd5, 4'd5, 1'b0);

`ifdef DECADE_LOAD_CHECK_EN
        // Out-of-range load rejected.
        step(1'b1, 1'b1, 1'b1, 4'd12, 4'd5, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd6, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4'd15, 4'd6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd5, 1'b0);
`else
        // Out-of-range load taken; recovery up -> 0, down -> 9.
        step(1'b1, 1'b1, 1'b1, 4'd12, 4'd12, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4'd15, 4'd15, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0);
`endif

        // Mid-count async reset pulse.
        step(1'b1, 1'b1, 1'b1, 4'd6, 4'd6, 1'b0);
        reset = 1'b0;
        chk_now(4'd0, 1'b0);
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0);

        // Drain: every pushed expectation must have been checked.
        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0 || n_cmp != n_push) begin
            n_err++;
            $display("FAIL drain: compared %0d, want %0d", n_cmp, n_push);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard stop if stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
